// File: rtl/realtank_soc_bus_out_stage_rr_if.sv
// Bus bundle between the input-stage decoders, the output stage and one AHB slave port.
// The output stage uses the master modport; the decoder/slave side uses the slave modport.
interface realtank_soc_bus_out_stage_rr_if #(
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned AW     = 32
);
    // Per-port requests from the decoders
    logic [NUM_IN-1:0]    sel_op;
    logic [NUM_IN*AW-1:0] addr_op;
    logic [NUM_IN*2-1:0]  trans_op;
    logic [NUM_IN-1:0]    write_op;
    logic [NUM_IN*3-1:0]  size_op;
    logic [NUM_IN*3-1:0]  burst_op;
    logic [NUM_IN-1:0]    lock_op;
    logic [NUM_IN*32-1:0] wdata_op;
    logic [NUM_IN-1:0]    active_op;

    // Slave side
    logic                 HREADYOUTM;
    logic                 HSELM;
    logic [AW-1:0]        HADDRM;
    logic [1:0]           HTRANSM;
    logic                 HWRITEM;
    logic [2:0]           HSIZEM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [31:0]          HWDATAM;
    logic                 HREADYMUXM;

    modport master (
        input  sel_op, addr_op, trans_op, write_op, size_op, burst_op, lock_op, wdata_op,
        input  HREADYOUTM,
        output active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HMASTLOCKM,
        output HWDATAM, HREADYMUXM
    );

    modport slave (
        output sel_op, addr_op, trans_op, write_op, size_op, burst_op, lock_op, wdata_op,
        output HREADYOUTM,
        input  active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HMASTLOCKM,
        input  HWDATAM, HREADYMUXM
    );
endinterface

// File: rtl/realtank_soc_bus_out_stage_rr.sv
// AHB bus-matrix output stage: round-robin arbiter that merges NUM_IN decoder requests onto
// one slave port, holding the grant for fixed/undefined-length bursts and locked sequences.
module realtank_soc_bus_out_stage_rr #(
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned AW     = 32
) (
    input  logic                                   HCLK,
    input  logic                                   HRESET,
    realtank_soc_bus_out_stage_rr_if.master        bus
);

    localparam int unsigned IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [2:0] BurstIncr   = 3'd1;
    localparam logic [2:0] BurstWrap4  = 3'd2;
    localparam logic [2:0] BurstIncr4  = 3'd3;
    localparam logic [2:0] BurstWrap8  = 3'd4;
    localparam logic [2:0] BurstIncr8  = 3'd5;
    localparam logic [2:0] BurstWrap16 = 3'd6;
    localparam logic [2:0] BurstIncr16 = 3'd7;

    typedef enum logic [1:0] {StArb, StHold, StLock} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [3:0]      beat_cnt_q, beat_cnt_d;
    logic            undef_q, undef_d;
    logic [IW-1:0]   last_grant_q;
    logic [IW-1:0]   data_port_q;
    logic            data_valid_q;

    logic [IW-1:0]   arb_grant;
    logic            arb_found;
    int unsigned     scan_idx;
    logic            keep_owner;
    logic [IW-1:0]   grant;
    logic            any_req;
    logic            hsel;

    // Per-port views of the flattened request buses
    logic [AW-1:0]   addr_a  [NUM_IN];
    logic [1:0]      trans_a [NUM_IN];
    logic [2:0]      size_a  [NUM_IN];
    logic [2:0]      burst_a [NUM_IN];
    logic [31:0]     wdata_a [NUM_IN];

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_port
        assign addr_a[gi]  = bus.addr_op[gi*AW +: AW];
        assign trans_a[gi] = bus.trans_op[gi*2 +: 2];
        assign size_a[gi]  = bus.size_op[gi*3 +: 3];
        assign burst_a[gi] = bus.burst_op[gi*3 +: 3];
        assign wdata_a[gi] = bus.wdata_op[gi*32 +: 32];
    end

    assign any_req = |bus.sel_op;

    // Round-robin scan: first requester after rr_ptr, wrapping; falls back to the last grant
    always_comb begin
        arb_grant = last_grant_q;
        arb_found = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NUM_IN) begin
                scan_idx = scan_idx - NUM_IN;
            end
            if (!arb_found && bus.sel_op[IW'(scan_idx)]) begin
                arb_grant = IW'(scan_idx);
                arb_found = 1'b1;
            end
        end
    end

    // Ownership hold: a burst owner keeps the port for SEQ/BUSY, a locked owner while locked
    // or still mid-transfer; anything else falls back to arbitration in the same cycle.
    always_comb begin
        keep_owner = 1'b0;
        case (state_q)
            StHold:  keep_owner = bus.sel_op[owner_q] && trans_a[owner_q][0];
            StLock:  keep_owner = bus.lock_op[owner_q] || (trans_a[owner_q] != TransIdle);
            default: keep_owner = 1'b0;
        endcase
        grant = keep_owner ? owner_q : arb_grant;
        hsel  = !HRESET && any_req && bus.sel_op[grant];
    end

    // Next-state: registered state only advances on HREADYOUTM
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        undef_d    = undef_q;
        if (bus.HREADYOUTM) begin
            if (keep_owner) begin
                // Only fixed-length bursts count beats; BUSY and locked transfers do not
                if (state_q == StHold && !undef_q && trans_a[owner_q] == TransSeq) begin
                    beat_cnt_d = beat_cnt_q - 4'd1;
                    if (beat_cnt_q <= 4'd1) begin
                        beat_cnt_d = 4'd0;
                        state_d    = StArb;
                    end
                end
            end else begin
                state_d    = StArb;
                beat_cnt_d = 4'd0;
                undef_d    = 1'b0;
                if (hsel && trans_a[grant] == TransNonseq) begin
                    rr_ptr_d = grant;
                    owner_d  = grant;
                    if (bus.lock_op[grant]) begin
                        state_d = StLock;
                    end else begin
                        case (burst_a[grant])
                            BurstWrap4, BurstIncr4: begin
                                state_d    = StHold;
                                beat_cnt_d = 4'd3;
                            end
                            BurstWrap8, BurstIncr8: begin
                                state_d    = StHold;
                                beat_cnt_d = 4'd7;
                            end
                            BurstWrap16, BurstIncr16: begin
                                state_d    = StHold;
                                beat_cnt_d = 4'd15;
                            end
                            BurstIncr: begin
                                state_d = StHold;
                                undef_d = 1'b1;
                            end
                            default: state_d = StArb;
                        endcase
                    end
                end
            end
        end
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= StArb;
            rr_ptr_q   <= IW'(NUM_IN - 1);
            owner_q    <= '0;
            beat_cnt_q <= 4'd0;
            undef_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            undef_q    <= undef_d;
        end
    end

    // Data-phase tracking: remembers which port owns the write data across wait states
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_grant_q <= '0;
            data_port_q  <= '0;
            data_valid_q <= 1'b0;
        end else if (bus.HREADYOUTM) begin
            last_grant_q <= grant;
            data_port_q  <= grant;
            data_valid_q <= hsel && bus.HTRANSM[1];
        end
    end

    // Slave address/control mux and one-hot ownership feedback to the decoders
    always_comb begin
        bus.active_op = '0;
        if (hsel) begin
            bus.active_op[grant] = 1'b1;
        end
        bus.HSELM      = hsel;
        bus.HTRANSM    = hsel ? trans_a[grant] : TransIdle;
        bus.HADDRM     = addr_a[grant];
        bus.HWRITEM    = bus.write_op[grant];
        bus.HSIZEM     = size_a[grant];
        bus.HBURSTM    = burst_a[grant];
        bus.HMASTLOCKM = bus.lock_op[grant];
        bus.HWDATAM    = wdata_a[data_port_q];
        bus.HREADYMUXM = bus.HREADYOUTM;
    end

    // A stalled data phase must keep pointing at the same write-data source
    a_data_port_stable : assert property (@(posedge HCLK) disable iff (HRESET)
        (data_valid_q && !bus.HREADYOUTM) |=> $stable(data_port_q));

endmodule

// File: tb/tb_realtank_soc_bus_out_stage_rr.sv
// Directed bench for the round-robin AHB output stage with hand-computed expectations.
module tb_realtank_soc_bus_out_stage_rr;

    localparam int unsigned NUM_IN = 3;
    localparam int unsigned AW     = 32;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

    logic HCLK;
    logic HRESET;
    int   n_vec = 0;
    int   n_err = 0;

    realtank_soc_bus_out_stage_rr_if #(.NUM_IN(NUM_IN), .AW(AW)) bus ();

    realtank_soc_bus_out_stage_rr #(.NUM_IN(NUM_IN), .AW(AW)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input int p, input logic sel, input logic [1:0] tr, input logic [2:0] bu,
                       input logic lk, input logic [31:0] ad);
        bus.sel_op[p]            = sel;
        bus.trans_op[p*2 +: 2]   = tr;
        bus.burst_op[p*3 +: 3]   = bu;
        bus.lock_op[p]           = lk;
        bus.addr_op[p*AW +: AW]  = ad;
    endtask

    task automatic wd(input int p, input logic [31:0] w);
        bus.wdata_op[p*32 +: 32] = w;
    endtask

    task automatic off(input int p);
        drv(p, 1'b0, IDLE, SINGLE, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET         = 1'b1;
        bus.sel_op     = '0;
        bus.addr_op    = '0;
        bus.trans_op   = '0;
        bus.write_op   = '0;
        bus.size_op    = {NUM_IN{3'd2}};
        bus.burst_op   = '0;
        bus.lock_op    = '0;
        bus.wdata_op   = '0;
        bus.HREADYOUTM = 1'b1;
        wd(0, 32'hA0); wd(1, 32'hA1); wd(2, 32'hA2);

        // Reset: outputs gated even with requests present
        drv(0, 1'b1, NSEQ, SINGLE, 1'b0, 32'h1000);
        drv(1, 1'b1, NSEQ, SINGLE, 1'b0, 32'h2000);
        tick(); tick();
        chk("rst_hsel", 32'(bus.HSELM), 32'd0);
        chk("rst_htrans", 32'(bus.HTRANSM), 32'd0);
        chk("rst_active", 32'(bus.active_op), 32'd0);
        chk("rst_rrptr", 32'(dut.rr_ptr_q), 32'd2);

        // Two SINGLE requesters alternate
        HRESET = 1'b0;
        #1;
        chk("rr0_active", 32'(bus.active_op), 32'b001);
        chk("rr0_addr", bus.HADDRM, 32'h1000);
        chk("rr0_htrans", 32'(bus.HTRANSM), 32'(NSEQ));
        tick();
        #1;
        chk("rr1_active", 32'(bus.active_op), 32'b010);
        chk("rr1_addr", bus.HADDRM, 32'h2000);
        chk("rr1_wdata", bus.HWDATAM, 32'hA0);
        tick();
        off(1);
        #1;
        chk("rr2_active", 32'(bus.active_op), 32'b001);
        chk("rr2_wdata", bus.HWDATAM, 32'hA1);
        tick();

        // Port1 INCR4 holds the port for 4 beats while port0 waits
        drv(1, 1'b1, NSEQ, INCR4, 1'b0, 32'h100);
        #1;
        chk("b4_active0", 32'(bus.active_op), 32'b010);
        chk("b4_addr0", bus.HADDRM, 32'h100);
        chk("b4_burst", 32'(bus.HBURSTM), 32'(INCR4));
        tick();
        for (int b = 1; b < 4; b++) begin
            drv(1, 1'b1, SEQ, INCR4, 1'b0, 32'h100 + 32'(b * 4));
            #1;
            chk("b4_active", 32'(bus.active_op), 32'b010);
            chk("b4_addr", bus.HADDRM, 32'h100 + 32'(b * 4));
            tick();
        end
        off(1);
        #1;
        chk("b4_cnt_done", 32'(dut.beat_cnt_q), 32'd0);
        chk("b4_port0_c5", 32'(bus.active_op), 32'b001);
        chk("b4_port0_addr", bus.HADDRM, 32'h1000);
        tick();

        // Port2 INCR4 with a BUSY beat and two wait states
        off(0);
        drv(2, 1'b1, NSEQ, INCR4, 1'b0, 32'h200);
        #1;
        chk("w_active0", 32'(bus.active_op), 32'b100);
        tick();
        drv(2, 1'b1, SEQ, INCR4, 1'b0, 32'h204);
        wd(2, 32'hD0);
        #1;
        chk("w_wdata0", bus.HWDATAM, 32'hD0);
        tick();
        drv(2, 1'b1, BUSY, INCR4, 1'b0, 32'h208);
        wd(2, 32'hD1);
        #1;
        chk("w_busy_trans", 32'(bus.HTRANSM), 32'(BUSY));
        tick();
        chk("w_busy_cnt", 32'(dut.beat_cnt_q), 32'd2);
        drv(2, 1'b1, SEQ, INCR4, 1'b0, 32'h208);
        bus.HREADYOUTM = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            chk("w_wait_wdata", bus.HWDATAM, 32'hD1);
            chk("w_wait_active", 32'(bus.active_op), 32'b100);
            tick();
            chk("w_wait_cnt", 32'(dut.beat_cnt_q), 32'd2);
        end
        bus.HREADYOUTM = 1'b1;
        tick();
        drv(2, 1'b1, SEQ, INCR4, 1'b0, 32'h20C);
        #1;
        chk("w_cnt_last", 32'(dut.beat_cnt_q), 32'd1);
        chk("w_addr_last", bus.HADDRM, 32'h20C);
        tick();

        // Port0 locked for three transfers while port1 requests
        off(2);
        drv(0, 1'b1, NSEQ, SINGLE, 1'b1, 32'h300);
        drv(1, 1'b1, NSEQ, SINGLE, 1'b0, 32'h400);
        #1;
        chk("lk_cnt_idle", 32'(dut.beat_cnt_q), 32'd0);
        chk("lk_active0", 32'(bus.active_op), 32'b001);
        chk("lk_mastlock", 32'(bus.HMASTLOCKM), 32'd1);
        tick();
        for (int t = 1; t < 3; t++) begin
            drv(0, 1'b1, NSEQ, SINGLE, 1'b1, 32'h300 + 32'(t * 4));
            #1;
            chk("lk_active", 32'(bus.active_op), 32'b001);
            tick();
        end
        drv(0, 1'b1, IDLE, SINGLE, 1'b0, 32'h30C);
        #1;
        chk("lk_release", 32'(bus.active_op), 32'b010);
        chk("lk_rel_addr", bus.HADDRM, 32'h400);
        chk("lk_rel_mlock", 32'(bus.HMASTLOCKM), 32'd0);
        tick();

        // INCR burst from port1 early-terminated by NONSEQ
        off(0);
        drv(1, 1'b1, NSEQ, INCR, 1'b0, 32'h500);
        #1;
        chk("inc_active0", 32'(bus.active_op), 32'b010);
        tick();
        drv(1, 1'b1, SEQ, INCR, 1'b0, 32'h504);
        #1;
        chk("inc_seq", 32'(bus.active_op), 32'b010);
        tick();
        drv(1, 1'b1, BUSY, INCR, 1'b0, 32'h508);
        #1;
        chk("inc_busy", 32'(bus.active_op), 32'b010);
        tick();
        drv(1, 1'b1, NSEQ, SINGLE, 1'b0, 32'h600);
        drv(2, 1'b1, NSEQ, SINGLE, 1'b0, 32'h700);
        #1;
        chk("inc_term_rr", 32'(dut.rr_ptr_q), 32'd1);
        chk("inc_term_act", 32'(bus.active_op), 32'b100);
        chk("inc_term_addr", bus.HADDRM, 32'h700);
        tick();
        off(2);
        #1;
        chk("inc_p1_after", 32'(bus.active_op), 32'b010);
        chk("inc_p1_addr", bus.HADDRM, 32'h600);
        tick();

        // Reset in the middle of an INCR8 burst
        drv(1, 1'b1, NSEQ, INCR8, 1'b0, 32'h800);
        #1;
        chk("r8_active0", 32'(bus.active_op), 32'b010);
        tick();
        drv(1, 1'b1, SEQ, INCR8, 1'b0, 32'h804);
        tick();
        drv(1, 1'b1, SEQ, INCR8, 1'b0, 32'h808);
        drv(0, 1'b1, NSEQ, SINGLE, 1'b0, 32'h900);
        #1;
        chk("r8_held", 32'(bus.active_op), 32'b010);
        HRESET = 1'b1;
        #1;
        chk("r8_rst_hsel", 32'(bus.HSELM), 32'd0);
        chk("r8_rst_active", 32'(bus.active_op), 32'd0);
        tick();
        HRESET = 1'b0;
        drv(1, 1'b1, SEQ, INCR8, 1'b0, 32'h80C);
        #1;
        chk("r8_cnt", 32'(dut.beat_cnt_q), 32'd0);
        chk("r8_rrptr", 32'(dut.rr_ptr_q), 32'd2);
        chk("r8_port0", 32'(bus.active_op), 32'b001);
        chk("r8_addr", bus.HADDRM, 32'h900);
        chk("r8_hsel", 32'(bus.HSELM), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
